// File: rtl/light_pattern_seq.sv
// Light pattern sequencer: FILL -> DRAIN (-> BLINK) -> FILL, one step every TICK_MAX cycles.
// Define LIGHT_PATTERN_SEQ_BLINK_EN to include the BLINK phase; without it DRAIN wraps straight to FILL.
module light_pattern_seq #(
    parameter int WIDTH       = 4,
    parameter int TICK_MAX    = 100_000_000,
    parameter int BLINK_STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic             dir,
    output logic [WIDTH-1:0] light,
    output logic [1:0]       phase,
    output logic             tick
);

    localparam int CNT_W    = $clog2(TICK_MAX + 1);
    localparam int STEP_MAX = (WIDTH > BLINK_STEPS) ? WIDTH : BLINK_STEPS;
    localparam int STEP_W   = $clog2(STEP_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        BLINK = 2'd2,
        BAD   = 2'd3
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STEP_W-1:0]  lastStep;
    logic [WIDTH-1:0]   pattern;

    assign tick  = run & ~rst & (cnt_q == CNT_LAST);
    assign phase = phase_q;

    always_comb begin
        lastStep = STEP_W'(WIDTH - 1);
        if (phase_q == BLINK) begin
            lastStep = STEP_W'(BLINK_STEPS - 1);
        end
    end

    // Restart and the illegal encoding both snap back to the start of FILL.
    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        if (restart || phase_q == BAD) begin
            phase_d = FILL;
            step_d  = '0;
            cnt_d   = '0;
        end else if (tick) begin
            cnt_d = '0;
            if (step_q == lastStep) begin
                step_d = '0;
                case (phase_q)
                    FILL:    phase_d = DRAIN;
`ifdef LIGHT_PATTERN_SEQ_BLINK_EN
                    DRAIN:   phase_d = BLINK;
`else
                    DRAIN:   phase_d = FILL;
`endif
                    default: phase_d = FILL;
                endcase
            end else begin
                step_d = step_q + 1'b1;
            end
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= FILL;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Patterns are built for dir=0 and mirrored afterwards; BLINK is symmetric so mirroring is harmless.
    always_comb begin
        pattern = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (phase_q)
                FILL:    pattern[i] = (i <= int'(step_q));
                DRAIN:   pattern[i] = ((i + int'(step_q)) < (WIDTH - 1));
                BLINK:   pattern[i] = ~step_q[0];
                default: pattern[i] = 1'b0;
            endcase
        end
        light = pattern;
        if (dir) begin
            for (int i = 0; i < WIDTH; i++) begin
                light[i] = pattern[WIDTH-1-i];
            end
        end
    end

endmodule

// File: tb/tb_light_pattern_seq.sv
// Scoreboard bench for light_pattern_seq; follows whichever LIGHT_PATTERN_SEQ_BLINK_EN setting the build uses.
module tb_light_pattern_seq;

    localparam int W  = 4;
    localparam int TM = 3;
    localparam int BS = 4;
`ifdef LIGHT_PATTERN_SEQ_BLINK_EN
    localparam int RST_PHASE = 2;
    localparam int PERIOD    = 36;
`else
    localparam int RST_PHASE = 1;
    localparam int PERIOD    = 24;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         restart = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] light;
    logic [1:0]   phase;
    logic         tick;
    logic [1:0]   light1;
    logic [1:0]   phase1;
    logic         tick1;

    light_pattern_seq #(.WIDTH(W), .TICK_MAX(TM), .BLINK_STEPS(BS)) dut (
        .clk(clk), .rst(rst), .run(run), .restart(restart), .dir(dir),
        .light(light), .phase(phase), .tick(tick)
    );

    light_pattern_seq #(.WIDTH(2), .TICK_MAX(1), .BLINK_STEPS(2)) dutFast (
        .clk(clk), .rst(rst), .run(run), .restart(restart), .dir(dir),
        .light(light1), .phase(phase1), .tick(tick1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] light;
        logic [1:0] phase;
        logic       tick;
        logic       tick1;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   mPhase = 0;
    int   mStep = 0;
    int   mCnt = 0;
    bit   mValid = 1'b0;
    logic [3:0] seqTab [13];
    logic [3:0] dirTab [8];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] modelLight(input int ph, input int s, input logic d);
        logic [3:0] v;
        case (ph)
            0:       v = 4'((1 << (s + 1)) - 1);
            1:       v = 4'((1 << (W - 1 - s)) - 1);
            2:       v = (s % 2 == 0) ? 4'hF : 4'h0;
            default: v = 4'h0;
        endcase
        if (d && ph != 2) v = {v[0], v[1], v[2], v[3]};
        return v;
    endfunction

    function automatic int phaseLen(input int ph);
        return (ph == 2) ? BS : W;
    endfunction

    function automatic int nextPhase(input int ph);
        if (ph == 0) return 1;
`ifdef LIGHT_PATTERN_SEQ_BLINK_EN
        if (ph == 1) return 2;
`endif
        return 0;
    endfunction

    task automatic checkScoreboard();
        exp_t e;
        logic hasItem;
        hasItem = (expQ.size() != 0);
        checkOutput("queueNotEmpty", 32'(hasItem), 32'd1);
        if (hasItem) begin
            e = expQ.pop_front();
            checkOutput("light", 32'(light), 32'(e.light));
            checkOutput("phase", 32'(phase), 32'(e.phase));
            checkOutput("tick", 32'(tick), 32'(e.tick));
            checkOutput("tickFast", 32'(tick1), 32'(e.tick1));
        end
    endtask

    // One clock cycle: drive inputs, queue the model's expectation, compare before the edge, then step the model.
    task automatic applyStimulus(input logic r, input logic rs, input logic rn, input logic d);
        exp_t e;
        @(negedge clk);
        rst = r;
        restart = rs;
        run = rn;
        dir = d;
        if (mValid) begin
            e.light = modelLight(mPhase, mStep, d);
            e.phase = 2'(mPhase);
            e.tick  = !r && rn && (mCnt == TM - 1);
            e.tick1 = !r && rn;
            expQ.push_back(e);
        end
        #2;
        if (mValid) checkScoreboard();
        if (r || rs) begin
            mPhase = 0;
            mStep  = 0;
            mCnt   = 0;
            mValid = 1'b1;
        end else if (mValid && rn) begin
            if (mCnt == TM - 1) begin
                mCnt = 0;
                if (mStep == phaseLen(mPhase) - 1) begin
                    mStep  = 0;
                    mPhase = nextPhase(mPhase);
                end else begin
                    mStep++;
                end
            end else begin
                mCnt++;
            end
        end
    endtask

    initial begin
        int  guard;
        logic found;
`ifdef LIGHT_PATTERN_SEQ_BLINK_EN
        seqTab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h1};
`else
        seqTab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'h7};
`endif
        dirTab = '{4'h8, 4'hC, 4'hE, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

        // Reset, then free-running sequence with dir=0
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 39; k++) begin
            applyStimulus(0, 0, 1, 0);
            if (k % 3 == 1) checkOutput($sformatf("seq%0d", k / 3), 32'(light), 32'(seqTab[k / 3]));
        end

        // Pause with cnt=1
        guard = 0;
        while (mCnt != 1 && guard < 10) begin
            applyStimulus(0, 0, 1, 0);
            guard++;
        end
        found = (mCnt == 1);
        checkOutput("findCnt1", 32'(found), 32'd1);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 1, 0);

        // Restart coincident with a tick at DRAIN step 2
        guard = 0;
        while (!(mPhase == 1 && mStep == 2 && mCnt == TM - 1) && guard < 80) begin
            applyStimulus(0, 0, 1, 0);
            guard++;
        end
        found = (mPhase == 1 && mStep == 2 && mCnt == TM - 1);
        checkOutput("findDrain2", 32'(found), 32'd1);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("restartLight", 32'(light), 32'h1);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 1, 0);

        // Mirrored direction from reset, then dir toggling mid-step
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        for (int k = 0; k < 24; k++) begin
            applyStimulus(0, 0, 1, 1);
            if (k % 3 == 1) checkOutput($sformatf("dir%0d", k / 3), 32'(light), 32'(dirTab[k / 3]));
        end
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 1, logic'(k % 2));

        // Reset in the middle of the last phase, overriding restart and run
        guard = 0;
        while (!(mPhase == RST_PHASE && mStep == 1 && mCnt == 1) && guard < 80) begin
            applyStimulus(0, 0, 1, 0);
            guard++;
        end
        found = (mPhase == RST_PHASE && mStep == 1 && mCnt == 1);
        checkOutput("findRstPoint", 32'(found), 32'd1);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 0, 1, 0);
        checkOutput("rstLight", 32'(light), 32'h1);
        checkOutput("rstTick", 32'(tick), 32'd0);
        for (int k = 0; k < 15; k++) applyStimulus(0, 0, 1, 0);

        // Three more full periods
        for (int k = 0; k < 3 * PERIOD + 5; k++) applyStimulus(0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_pattern_seq.md
LIGHT_PATTERN_SEQ -- requirements
Module: light_pattern_seq

Interface
REQ-001 Parameter WIDTH, default 4: number of lights; legal range 2..32.
REQ-002 Parameter TICK_MAX, default 100_000_000: clk cycles per step; legal when >= 1.
REQ-003 Parameter BLINK_STEPS, default 4: steps in the BLINK phase; must be even and >= 2.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 run  input  1: step counter advances while 1 and holds while 0.
REQ-007 restart  input  1: synchronous return to the start of the sequence.
REQ-008 dir  input  1: 0 = fill from bit 0 upward; 1 = mirrored, fill from bit WIDTH-1 downward.
REQ-009 light  output  WIDTH: light pattern, combinational from registered state and dir.
REQ-010 phase  output  2: current phase, where FILL=0, DRAIN=1, BLINK=2.
REQ-011 tick  output  1: one-cycle pulse marking a step boundary.

Function
REQ-012 The cycle counter cnt SHALL be $clog2(TICK_MAX+1) bits wide and count 0..TICK_MAX-1 only while run=1.
REQ-013 tick SHALL equal run AND (cnt == TICK_MAX-1); on a tick edge, cnt SHALL wrap to 0 and step SHALL advance.
REQ-014 When TICK_MAX=1, tick SHALL assert on every cycle with run=1.
REQ-015 When run=0, cnt, step and phase SHALL hold, and tick SHALL be 0.
REQ-016 FILL SHALL last WIDTH steps; at step s, the light SHALL show s+1 ones from bit 0 (dir=0).
REQ-017 DRAIN SHALL last WIDTH steps; at step s, the light SHALL show WIDTH-1-s ones from bit 0 (dir=0); the last step shows all zeros.
REQ-018 BLINK SHALL last BLINK_STEPS steps; the light SHALL be all ones on even steps and all zeros on odd steps.
REQ-019 With dir=1, the FILL and DRAIN patterns SHALL be bit-reversed; BLINK SHALL be unaffected.
REQ-020 A change on dir SHALL affect light in the same cycle, with no state change.
REQ-021 On a tick at the last step of a phase, step SHALL become 0 and the phase SHALL advance: FILL->DRAIN, DRAIN->BLINK, BLINK->FILL.
REQ-022 Latency: light SHALL show the new step in the cycle after the tick edge.
REQ-023 restart=1 SHALL set phase=FILL, step=0 and cnt=0 at the next edge, regardless of run.
REQ-024 restart SHALL override a simultaneous tick.
REQ-025 Illegal phase 3 SHALL drive light all zeros and SHALL recover to FILL step 0 at the next edge.

Reset
REQ-026 rst SHALL set phase=FILL, step=0 and cnt=0 at the next edge.
REQ-027 While in reset: light=0...01 (dir=0), phase=0, tick=0.
REQ-028 rst SHALL take priority over restart and run, including in the middle of a step or phase.

Configuration
REQ-029 Macro LIGHT_PATTERN_SEQ_BLINK_EN SHALL control whether the BLINK phase exists.
REQ-030 With LIGHT_PATTERN_SEQ_BLINK_EN defined: the full FILL->DRAIN->BLINK->FILL cycle runs, and BLINK_STEPS is honoured.
REQ-031 Without LIGHT_PATTERN_SEQ_BLINK_EN: DRAIN's last step SHALL go directly to FILL.
REQ-032 Without the macro, phase SHALL never equal 2, and BLINK_STEPS SHALL be ignored.

Verification
REQ-033 WIDTH=4, TICK_MAX=3, BLINK_STEPS=4, macro defined, rst 2 cycles then run=1, dir=0 -> light changes every 3 cycles: 0001,0011,0111,1111,0111,0011,0001,0000,1111,0000,1111,0000,0001 (period 36 cycles).
REQ-034 Same parameters; run dropped for 5 cycles when cnt=1 -> light, cnt and phase frozen, tick=0; after run returns, the next tick comes 2 run-cycles later.
REQ-035 dir=1 from reset -> FILL shows 1000,1100,1110,1111, then DRAIN shows 1110,1100,1000,0000.
REQ-036 restart pulsed during DRAIN step 2 (light 0001), coincident with a tick -> next cycle light=0001, phase=0, and the next tick comes 3 cycles later.
REQ-037 Macro undefined, WIDTH=4 -> after DRAIN light 0000 the next step is 0001 with phase=0; phase is never observed at 2 across 3 full periods.
REQ-038 rst asserted in BLINK step 1 -> next cycle light=0001, phase=0, tick=0; the sequence restarts from FILL step 0 once rst is released.
